// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multi-cycle RV32I core.
//
// Sequences FETCH / DECODE / EXEC / MEM / WB / BRANCH over one shared ALU and a
// single unified memory port. Flags unsupported opcodes and memory timeouts,
// both sticky until reset.
//
// Build option: define CTRL_BRANCH_EN to execute beq (1100011) through the
// BRANCH state. Without it beq is treated as an illegal opcode and pc_branch
// is tied low.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode[6:0]      IR[6:0], stable from DECODE until the next fetch completes
//   mem_ready        memory completes the current access this cycle
//   alu_zero         ALU result == 0, used in BRANCH
//   mem_req/mem_we   memory request / write strobe
//   iord             memory address select: 0 = PC, 1 = ALUOut
//   ir_write         load IR from memory data
//   pc_write         PC <= PC+4
//   pc_branch        PC <= branch target
//   alu_src_b[1:0]   00 = rs2, 01 = const 4, 10 = imm
//   alu_op[1:0]      00 = add, 01 = sub, 10 = funct decode
//   reg_write        register-file write enable
//   wb_sel           0 = ALUOut, 1 = MDR
//   retire           one-cycle pulse per completed instruction
//   illegal/bus_err  sticky error flags
//   state_dbg[2:0]   current state encoding
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_branch,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    HALT   = 3'd7
  } state_t;

  // Counter must hold TIMEOUT-1 and saturate; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state, nxt;
  logic [CW-1:0] wait_cnt;
  logic          set_illegal, set_bus_err, tmo_hit;
  logic          retire_q;

  // Opcode decode; valid from DECODE onward because IR is held until next fetch.
  logic is_load, is_store, is_rtype, is_itype, is_beq, is_mem, is_alu;
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_rtype = (opcode == 7'b0110011);
  assign is_itype = (opcode == 7'b0010011);
  assign is_beq   = (opcode == 7'b1100011);
  assign is_mem   = is_load | is_store;
  assign is_alu   = is_rtype | is_itype;

  // Timeout fires on the TIMEOUT-th consecutive unaccepted request cycle.
  assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == TMO_LAST) && !mem_ready;

  always_comb begin
    nxt         = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      BOOT:   nxt = FETCH;
      FETCH: begin
        if (mem_ready)    nxt = DECODE;
        else if (tmo_hit) begin nxt = HALT; set_bus_err = 1'b1; end
      end
      DECODE: begin
        if (is_mem || is_alu) nxt = EXEC;
`ifdef CTRL_BRANCH_EN
        else if (is_beq)      nxt = BRANCH;
`endif
        else begin nxt = HALT; set_illegal = 1'b1; end
      end
      EXEC:   nxt = is_mem ? MEM : WB;
      MEM: begin
        if (mem_ready)    nxt = is_load ? WB : FETCH;
        else if (tmo_hit) begin nxt = HALT; set_bus_err = 1'b1; end
      end
      WB:     nxt = FETCH;
      BRANCH: nxt = FETCH;
      default: nxt = HALT;
    endcase
  end

  // State, error flags and the state-derived outputs are all registered; the
  // outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      iord      <= 1'b0;
      alu_src_b <= 2'b00;
      alu_op    <= 2'b00;
      reg_write <= 1'b0;
      wb_sel    <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state   <= nxt;
      illegal <= illegal | set_illegal;
      bus_err <= bus_err | set_bus_err;

      if (nxt != state || !mem_req || mem_ready) wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX)              wait_cnt <= wait_cnt + 1'b1;

      mem_req   <= (nxt == FETCH) || (nxt == MEM);
      iord      <= (nxt == MEM);
      mem_we    <= (nxt == MEM) && is_store;
      reg_write <= (nxt == WB);
      wb_sel    <= (nxt == WB) && is_load;
      retire_q  <= (nxt == WB) || (nxt == BRANCH);

      alu_src_b <= 2'b00;
      alu_op    <= 2'b00;
      case (nxt)
        DECODE: alu_src_b <= 2'b10;                       // branch target precompute
        EXEC: begin
          alu_src_b <= is_rtype ? 2'b00 : 2'b10;
          alu_op    <= is_mem   ? 2'b00 : 2'b10;
        end
        BRANCH: alu_op <= 2'b01;                          // rs1 - rs2 for beq compare
        default: ;
      endcase
    end
  end

  // Strobes qualified by the completing handshake must be combinational so
  // they land in the acceptance cycle itself.
  assign ir_write  = (state == FETCH) && mem_ready;
  assign pc_write  = (state == FETCH) && mem_ready;
  assign retire    = retire_q | ((state == MEM) && mem_ready && is_store);
  assign state_dbg = state;

`ifdef CTRL_BRANCH_EN
  assign pc_branch = (state == BRANCH) && alu_zero;
`else
  assign pc_branch = 1'b0;
  logic unused_branch;
  assign unused_branch = alu_zero ^ is_beq;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side drives one cycle of
// inputs at a time and queues the hand-derived output vector expected for that
// cycle; a monitor on the falling edge pops and compares.
// Vector layout: {state[2:0], mem_req, mem_we, iord, ir_write, pc_write,
//                 pc_branch, alu_src_b[1:0], alu_op[1:0],
//                 reg_write, wb_sel, retire, illegal, bus_err}
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready, alu_zero;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_branch;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_write, wb_sel, retire, illegal, bus_err;
  logic [2:0] state_dbg;

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // strobe group = {mem_req, mem_we, iord, ir_write, pc_write, pc_branch}
  // tail group   = {reg_write, wb_sel, retire, illegal, bus_err}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FWAIT = 6'b100000;
  localparam logic [5:0] S_FACC  = 6'b100110;
  localparam logic [5:0] S_LDMEM = 6'b101000;
  localparam logic [5:0] S_STMEM = 6'b111000;
  localparam logic [5:0] S_BTAKE = 6'b000001;

  function automatic logic [17:0] v(input logic [2:0] st, input logic [5:0] strb,
                                    input logic [1:0] sb, input logic [1:0] op,
                                    input logic [4:0] tail);
    return {st, strb, sb, op, tail};
  endfunction

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  // One stimulus cycle: drive inputs just after the rising edge, queue the
  // expected outputs for that cycle.
  task automatic cyc(input logic rst, input logic rdy, input logic az,
                     input logic [17:0] e, input string tag);
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ready = rdy;
    alu_zero  = az;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic reset_pulse();
    cyc(1'b0, 1'b0, 1'b0, 18'd0, "rst_low");
    cyc(1'b1, 1'b0, 1'b0, 18'd0, "boot");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e, got;
      string t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {state_dbg, mem_req, mem_we, iord, ir_write, pc_write, pc_branch,
             alu_src_b, alu_op, reg_write, wb_sel, retire, illegal, bus_err};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b at %0t", t,
                 got[17:15], got[14:9], got[8:7], got[6:5], got[4:0],
                 e[17:15], e[14:9], e[8:7], e[6:5], e[4:0], $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; opcode = OP_ADDI; mem_ready = 1'b0; alu_zero = 1'b0;
    #2 rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 18'd0, "reset");
    cyc(1'b0, 1'b1, 1'b1, 18'd0, "reset_in_ignored");
    cyc(1'b1, 1'b0, 1'b0, 18'd0, "boot");

    // addi, memory always ready; ready during DECODE is ignored
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "addi_fetch");
    cyc(1, 1, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "addi_dec");
    cyc(1, 0, 0, v(3, S_NONE, 2'b10, 2'b10, 5'b00000), "addi_exec");
    cyc(1, 0, 0, v(5, S_NONE, 2'b00, 2'b00, 5'b10100), "addi_wb");

    // lw with three wait states in FETCH and in MEM
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, v(1, S_FWAIT, 2'b00, 2'b00, 5'b00000), "lw_fetch_wait");
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "lw_fetch");
    opcode = OP_LW;
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "lw_dec");
    cyc(1, 0, 0, v(3, S_NONE, 2'b10, 2'b00, 5'b00000), "lw_exec");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, v(4, S_LDMEM, 2'b00, 2'b00, 5'b00000), "lw_mem_wait");
    cyc(1, 1, 0, v(4, S_LDMEM, 2'b00, 2'b00, 5'b00000), "lw_mem");
    cyc(1, 0, 0, v(5, S_NONE, 2'b00, 2'b00, 5'b11100), "lw_wb");

    // sw, one wait state in MEM, retire on acceptance
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "sw_fetch");
    opcode = OP_SW;
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "sw_dec");
    cyc(1, 0, 0, v(3, S_NONE, 2'b10, 2'b00, 5'b00000), "sw_exec");
    cyc(1, 0, 0, v(4, S_STMEM, 2'b00, 2'b00, 5'b00000), "sw_mem_wait");
    cyc(1, 1, 0, v(4, S_STMEM, 2'b00, 2'b00, 5'b00100), "sw_mem");

    // beq
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "beq_fetch");
    opcode = OP_BEQ;
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "beq_dec");
`ifdef CTRL_BRANCH_EN
    cyc(1, 0, 1, v(6, S_BTAKE, 2'b00, 2'b01, 5'b00100), "beq_taken");
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "beq2_fetch");
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "beq2_dec");
    cyc(1, 0, 0, v(6, S_NONE, 2'b00, 2'b01, 5'b00100), "beq_not_taken");
`else
    for (int i = 0; i < 3; i++)
      cyc(1, i[0], 1, v(7, S_NONE, 2'b00, 2'b00, 5'b00010), "beq_illegal_halt");
    reset_pulse();
`endif

    // unsupported opcode: HALT with sticky illegal, then reset clears it
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "bad_fetch");
    opcode = OP_BAD;
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "bad_dec");
    for (int i = 0; i < 20; i++)
      cyc(1, i[0], 0, v(7, S_NONE, 2'b00, 2'b00, 5'b00010), "bad_halt");
    reset_pulse();

    // ready on the 16th request cycle wins over the timeout
    opcode = OP_ADDI;
    for (int i = 0; i < 15; i++)
      cyc(1, 0, 0, v(1, S_FWAIT, 2'b00, 2'b00, 5'b00000), "edge_fetch_wait");
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "edge_fetch_acc");
    cyc(1, 0, 0, v(2, S_NONE, 2'b10, 2'b00, 5'b00000), "edge_dec");
    cyc(1, 0, 0, v(3, S_NONE, 2'b10, 2'b10, 5'b00000), "edge_exec");
    cyc(1, 0, 0, v(5, S_NONE, 2'b00, 2'b00, 5'b10100), "edge_wb");

    // 16 unaccepted request cycles -> HALT with bus_err
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 0, v(1, S_FWAIT, 2'b00, 2'b00, 5'b00000), "tmo_fetch_wait");
    for (int i = 0; i < 3; i++)
      cyc(1, i[0], 0, v(7, S_NONE, 2'b00, 2'b00, 5'b00001), "tmo_halt");
    reset_pulse();

    // reset dropped mid-wait: outputs clear immediately, then a clean restart
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, v(1, S_FWAIT, 2'b00, 2'b00, 5'b00000), "mid_fetch_wait");
    cyc(1'b0, 1'b0, 1'b0, 18'd0, "mid_rst_low");
    cyc(1'b0, 1'b1, 1'b0, 18'd0, "mid_rst_low2");
    cyc(1'b1, 1'b0, 1'b0, 18'd0, "mid_boot");
    cyc(1, 0, 0, v(1, S_FWAIT, 2'b00, 2'b00, 5'b00000), "restart_fetch_wait");
    cyc(1, 1, 0, v(1, S_FACC, 2'b00, 2'b00, 5'b00000), "restart_fetch");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
